// File: rtl/crc_seq_ctrl.sv
// crc_seq_ctrl: sequential driver for the crc3_eval step function.
// Accepts a job descriptor (length, polynomial, initial remainder), then
// consumes one WCODE-bit chunk per accepted beat, chaining the remainder,
// and presents the final remainder on a valid/ready result channel.
// Optional build macro CRC_SEQ_CHECK_EN adds an expected-CRC compare
// (i_exp_crc in, o_crc_err out).

// crc3_eval: combinational CRC step F(d,p,c).
// Only the low WPOLY-1 bits of the working value reach the result, and XOR
// has no carries, so each stage tracks just those low bits.
module crc3_eval #(
   parameter int WCODE = 4,
   parameter int WPOLY = 3
) (
   input  logic [WCODE-1:0] i_data,
   input  logic [WPOLY-1:0] i_poly,
   input  logic [WPOLY-2:0] i_crc,
   output logic [WPOLY-2:0] o_crc
);
   localparam int TW = WCODE + WPOLY - 1;

   logic [TW-1:0]    q_base;
   logic [WPOLY-2:0] t_stage [WCODE+1];

   assign q_base     = {i_poly, {(WCODE-1){1'b0}}};
   assign t_stage[0] = i_crc;

   genvar gi;
   generate
      for (gi = 0; gi < WCODE; gi++) begin : g_step
         logic [WPOLY-2:0] q_low;
         // polynomial aligned for data bit WCODE-1-gi, truncated to the remainder width
         assign q_low = (WPOLY-1)'(q_base >> gi);
         assign t_stage[gi+1] = i_data[WCODE-1-gi] ? (t_stage[gi] ^ q_low) : t_stage[gi];
      end
   endgenerate

   assign o_crc = t_stage[WCODE];
endmodule

module crc_seq_ctrl #(
   parameter int WCODE = 4,
   parameter int WPOLY = 3,
   parameter int LENW  = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [LENW-1:0]  i_len,
   input  logic [WPOLY-1:0] i_poly,
   input  logic [WPOLY-2:0] i_init,
   input  logic [WCODE-1:0] i_data,
   input  logic             i_data_valid,
   output logic             o_data_ready,
   output logic [WPOLY-2:0] o_crc,
   output logic             o_crc_valid,
   input  logic             i_crc_ready,
`ifdef CRC_SEQ_CHECK_EN
   input  logic [WPOLY-2:0] i_exp_crc,
   output logic             o_crc_err,
`endif
   output logic             o_busy
);
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           state;
   logic [LENW-1:0]  cnt;
   logic [WPOLY-1:0] poly_r;
   logic [WPOLY-2:0] crc_r;
   logic [WPOLY-2:0] crc_next;

   crc3_eval #(
      .WCODE (WCODE),
      .WPOLY (WPOLY)
   ) u_eval (
      .i_data (i_data),
      .i_poly (poly_r),
      .i_crc  (crc_r),
      .o_crc  (crc_next)
   );

`ifdef CRC_SEQ_CHECK_EN
   logic [WPOLY-2:0] exp_r;

   // expected remainder latched at job start
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         exp_r <= '0;
      else if (state == S_IDLE && i_start)
         exp_r <= i_exp_crc;
   end

   // mismatch flag is only meaningful while a result is presented
   assign o_crc_err = o_crc_valid && (crc_r != exp_r);
`endif

   // job FSM; all handshake outputs are registered alongside the state
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= S_IDLE;
         cnt          <= '0;
         poly_r       <= '0;
         crc_r        <= '0;
         o_crc        <= '0;
         o_crc_valid  <= 1'b0;
         o_data_ready <= 1'b0;
         o_busy       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  poly_r <= i_poly;
                  crc_r  <= i_init;
                  cnt    <= i_len;
                  o_busy <= 1'b1;
                  if (i_len == '0) begin
                     // empty message: result is the initial remainder
                     state       <= S_DONE;
                     o_crc       <= i_init;
                     o_crc_valid <= 1'b1;
                  end else begin
                     state        <= S_BUSY;
                     o_data_ready <= 1'b1;
                  end
               end
            end
            S_BUSY: begin
               if (i_data_valid && o_data_ready) begin
                  crc_r <= crc_next;
                  cnt   <= cnt - LENW'(1);
                  if (cnt == LENW'(1)) begin
                     state        <= S_DONE;
                     o_data_ready <= 1'b0;
                     o_crc        <= crc_next;
                     o_crc_valid  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               // i_start is not looked at here, so a request on the exit cycle waits one cycle
               if (i_crc_ready) begin
                  state       <= S_IDLE;
                  o_crc_valid <= 1'b0;
                  o_busy      <= 1'b0;
               end
            end
            default: begin
               state        <= S_IDLE;
               o_crc_valid  <= 1'b0;
               o_data_ready <= 1'b0;
               o_busy       <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_crc_seq_ctrl.sv
// Testbench for crc_seq_ctrl: directed scenarios plus randomized jobs,
// checked against a remainder model computed from the step-function rule.
// Define CRC_SEQ_CHECK_EN to also exercise the expected-CRC compare.
module tb_crc_seq_ctrl;
   localparam int WCODE = 4;
   localparam int WPOLY = 3;
   localparam int LENW  = 8;

   logic             clk = 1'b0;
   logic             i_rst_n;
   logic             i_start;
   logic [LENW-1:0]  i_len;
   logic [WPOLY-1:0] i_poly;
   logic [WPOLY-2:0] i_init;
   logic [WCODE-1:0] i_data;
   logic             i_data_valid;
   logic             o_data_ready;
   logic [WPOLY-2:0] o_crc;
   logic             o_crc_valid;
   logic             i_crc_ready;
   logic             o_busy;
`ifdef CRC_SEQ_CHECK_EN
   logic [WPOLY-2:0] i_exp_crc;
   logic             o_crc_err;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   crc_seq_ctrl #(.WCODE(WCODE), .WPOLY(WPOLY), .LENW(LENW)) dut (
      .i_clk        (clk),
      .i_rst_n      (i_rst_n),
      .i_start      (i_start),
      .i_len        (i_len),
      .i_poly       (i_poly),
      .i_init       (i_init),
      .i_data       (i_data),
      .i_data_valid (i_data_valid),
      .o_data_ready (o_data_ready),
      .o_crc        (o_crc),
      .o_crc_valid  (o_crc_valid),
      .i_crc_ready  (i_crc_ready),
`ifdef CRC_SEQ_CHECK_EN
      .i_exp_crc    (i_exp_crc),
      .o_crc_err    (o_crc_err),
`endif
      .o_busy       (o_busy)
   );

   // Remainder after a whole message: each set data bit i folds the
   // polynomial shifted left by i into the remainder (low bits only).
   function automatic logic [1:0] model_crc(input logic [2:0] p, input logic [1:0] c,
                                            input logic [3:0] d[$]);
      logic [1:0] r;
      int pv;
      r = c;
      foreach (d[k])
         for (int i = 0; i < WCODE; i++)
            if (d[k][i]) begin
               pv = int'(p) << i;
               r  = r ^ pv[1:0];
            end
      return r;
   endfunction

   // Runs one job: start, beats with random stalls (garbage starts during
   // stalls), then waits for the result. lat counts cycles beyond the one
   // right after the last beat.
   task automatic drive_job(input int len, input logic [2:0] p, input logic [1:0] c,
                            input logic [3:0] d[$], input int max_stall,
                            output logic [1:0] got, output int lat, output bit tmo);
      int st;
      int w;
      tmo = 1'b0;
      lat = 0;
      got = 'x;
      i_start = 1'b1; i_len = LENW'(len); i_poly = p; i_init = c;
      @(negedge clk);
      i_start = 1'b0;
      for (int k = 0; k < len; k++) begin
         st = (max_stall > 0) ? $urandom_range(max_stall, 0) : 0;
         repeat (st) begin
            i_data_valid = 1'b0;
            i_data  = 4'($urandom);
            i_start = 1'($urandom);
            i_len   = LENW'($urandom);
            i_init  = 2'($urandom);
            @(negedge clk);
         end
         i_start = 1'b0;
         i_data = d[k];
         i_data_valid = 1'b1;
         w = 0;
         while (o_data_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
         end
         if (w >= 20) begin
            tmo = 1'b1;
            i_data_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      i_data_valid = 1'b0;
      while (o_crc_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 20) tmo = 1'b1;
      got = o_crc;
   endtask

   // Holds the result for 'hold' cycles, then takes it; reports observations.
   task automatic consume(input int hold, output bit stable, output bit idle);
      logic [1:0] c0;
      c0 = o_crc;
      stable = 1'b1;
      i_crc_ready = 1'b0;
      repeat (hold) begin
         @(negedge clk);
         if (o_crc !== c0 || o_crc_valid !== 1'b1) stable = 1'b0;
      end
      i_crc_ready = 1'b1;
      @(negedge clk);
      i_crc_ready = 1'b0;
      idle = (o_crc_valid === 1'b0 && o_busy === 1'b0 && o_data_ready === 1'b0);
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0; i_start = 1'b0; i_len = '0; i_poly = '0; i_init = '0;
      i_data = 4'hF; i_data_valid = 1'b1; i_crc_ready = 1'b0;
`ifdef CRC_SEQ_CHECK_EN
      i_exp_crc = '0;
`endif
      repeat (2) @(negedge clk);
      checks++;
      if ({o_busy, o_data_ready, o_crc_valid, o_crc} !== 5'b0)
         $display("FAIL reset_hold: got busy/rdy/vld/crc=%b required 00000",
                  {o_busy, o_data_ready, o_crc_valid, o_crc});
      i_rst_n = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         checks++;
         if ({o_busy, o_data_ready, o_crc_valid, o_crc} !== 5'b0) begin
            failures++;
            $display("FAIL reset_idle cycle %0d: got busy/rdy/vld/crc=%b required 00000",
                     n, {o_busy, o_data_ready, o_crc_valid, o_crc});
         end
      end
      i_data_valid = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_single_chunk();
      logic [3:0] dq[$];
      logic [3:0] dv[2] = '{4'b0001, 4'b1111};
      logic [1:0] ev[2] = '{2'b01, 2'b11};
      logic [1:0] got;
      int lat;
      bit tmo, stable, idle;
      for (int n = 0; n < 2; n++) begin
         dq.delete();
         dq.push_back(dv[n]);
         drive_job(1, 3'b101, 2'b00, dq, 0, got, lat, tmo);
         checks++;
         if (tmo || got !== ev[n] || lat != 0) begin
            failures++;
            $display("FAIL single_chunk data=%b: got crc=%b lat=%0d tmo=%0d required crc=%b lat=0",
                     dv[n], got, lat, tmo, ev[n]);
         end
         consume(0, stable, idle);
         checks++;
         if (!idle) begin
            failures++;
            $display("FAIL single_chunk_release: got vld=%b busy=%b required 0 0", o_crc_valid, o_busy);
         end
         $display("single_chunk data=%b crc=%b", dv[n], got);
      end
   endtask

   task automatic test_chain_stalls();
      bit ok;
      i_start = 1'b1; i_len = 8'd2; i_poly = 3'b101; i_init = 2'b00;
      @(negedge clk);
      i_start = 1'b0;
      i_data = 4'b0001; i_data_valid = 1'b1;
      @(negedge clk);
      i_data_valid = 1'b0;
      ok = 1'b1;
      repeat (3) begin
         if (o_data_ready !== 1'b1 || o_crc_valid !== 1'b0) ok = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL chain_stall_ready: got ready dropped or early valid required ready=1 vld=0");
      end
      i_data = 4'b0001; i_data_valid = 1'b1;
      @(negedge clk);
      i_data_valid = 1'b0;
      checks++;
      if (o_crc_valid !== 1'b1 || o_crc !== 2'b00) begin
         failures++;
         $display("FAIL chain_result: got vld=%b crc=%b required vld=1 crc=00", o_crc_valid, o_crc);
      end
      i_crc_ready = 1'b1;
      @(negedge clk);
      i_crc_ready = 1'b0;
      $display("chain_stalls crc=00 expected");
   endtask

   task automatic test_zero_len_backpressure();
      logic [3:0] dq[$];
      logic [1:0] got;
      int lat;
      bit tmo, stable, idle;
      dq.delete();
      drive_job(0, 3'b101, 2'b10, dq, 0, got, lat, tmo);
      checks++;
      if (tmo || got !== 2'b10 || lat != 0) begin
         failures++;
         $display("FAIL zero_len: got crc=%b lat=%0d tmo=%0d required crc=10 lat=0", got, lat, tmo);
      end
      // a new request during the held result must be ignored
      i_start = 1'b1; i_len = 8'd0; i_init = 2'b01; i_poly = 3'b111;
      consume(5, stable, idle);
      i_start = 1'b0;
      checks++;
      if (!stable) begin
         failures++;
         $display("FAIL zero_len_hold: got result changed during backpressure required stable crc=10");
      end
      checks++;
      if (!idle) begin
         failures++;
         $display("FAIL zero_len_exit: got vld=%b busy=%b required 0 0 (start on exit cycle)", o_crc_valid, o_busy);
      end
      $display("zero_len_backpressure crc=%b", got);
   endtask

   task automatic test_reset_mid_job();
      logic [3:0] dq[$];
      logic [1:0] got;
      int lat;
      bit tmo, stable, idle;
      i_start = 1'b1; i_len = 8'd4; i_poly = 3'b101; i_init = 2'b11;
      @(negedge clk);
      i_start = 1'b0;
      i_data = 4'b1010; i_data_valid = 1'b1;
      repeat (2) @(negedge clk);
      i_rst_n = 1'b0;
      #1;
      checks++;
      if ({o_busy, o_data_ready, o_crc_valid, o_crc} !== 5'b0) begin
         failures++;
         $display("FAIL reset_mid_job: got busy/rdy/vld/crc=%b required 00000",
                  {o_busy, o_data_ready, o_crc_valid, o_crc});
      end
      @(negedge clk);
      i_data_valid = 1'b0;
      i_rst_n = 1'b1;
      @(negedge clk);
      dq.push_back(4'b0001);
      drive_job(1, 3'b101, 2'b00, dq, 0, got, lat, tmo);
      checks++;
      if (tmo || got !== 2'b01) begin
         failures++;
         $display("FAIL reset_new_job: got crc=%b tmo=%0d required crc=01", got, tmo);
      end
      consume(0, stable, idle);
      $display("reset_mid_job new crc=%b", got);
   endtask

   task automatic test_back_to_back();
      logic [3:0] dq[$];
      logic [1:0] got;
      int lat;
      bit tmo;
      dq.push_back(4'b0110);
      drive_job(1, 3'b111, 2'b01, dq, 0, got, lat, tmo);
      // take the result and request the next job in the same cycle
      i_crc_ready = 1'b1; i_start = 1'b1; i_len = 8'd1; i_poly = 3'b011; i_init = 2'b10;
      @(negedge clk);
      i_crc_ready = 1'b0;
      checks++;
      if (o_busy !== 1'b0 || o_crc_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_exit_start: got busy=%b vld=%b required 0 0", o_busy, o_crc_valid);
      end
      dq.delete();
      dq.push_back(4'b1001);
      drive_job(1, 3'b011, 2'b10, dq, 0, got, lat, tmo);
      checks++;
      if (tmo || got !== model_crc(3'b011, 2'b10, dq)) begin
         failures++;
         $display("FAIL b2b_second: got crc=%b required %b", got, model_crc(3'b011, 2'b10, dq));
      end
      i_crc_ready = 1'b1;
      @(negedge clk);
      i_crc_ready = 1'b0;
      $display("back_to_back second crc=%b", got);
   endtask

   task automatic test_random();
      logic [3:0] dq[$];
      logic [2:0] p;
      logic [1:0] c, got, exp;
      int len, lat;
      bit tmo, stable, idle;
      for (int j = 0; j < 25; j++) begin
         len = $urandom_range(6, 0);
         p = 3'($urandom);
         c = 2'($urandom);
         dq.delete();
         for (int k = 0; k < len; k++) dq.push_back(4'($urandom));
         exp = model_crc(p, c, dq);
         drive_job(len, p, c, dq, 3, got, lat, tmo);
         checks++;
         if (tmo || got !== exp || lat != 0) begin
            failures++;
            $display("FAIL random job %0d len=%0d: got crc=%b lat=%0d tmo=%0d required crc=%b lat=0",
                     j, len, got, lat, tmo, exp);
         end
         consume($urandom_range(3, 0), stable, idle);
         checks++;
         if (!stable || !idle) begin
            failures++;
            $display("FAIL random_handoff job %0d: got stable=%0d idle=%0d required 1 1", j, stable, idle);
         end
         $display("random job %0d len=%0d poly=%b init=%b crc=%b", j, len, p, c, got);
      end
   endtask

`ifdef CRC_SEQ_CHECK_EN
   task automatic test_check_en();
      logic [3:0] dq[$];
      logic [1:0] ex[2] = '{2'b01, 2'b10};
      logic [1:0] got;
      int lat;
      bit tmo, stable, idle;
      dq.push_back(4'b0001);
      for (int n = 0; n < 2; n++) begin
         i_exp_crc = ex[n];
         drive_job(1, 3'b101, 2'b00, dq, 0, got, lat, tmo);
         checks++;
         if (tmo || o_crc_err !== (n == 1)) begin
            failures++;
            $display("FAIL check_err exp=%b: got err=%b required %b", ex[n], o_crc_err, (n == 1));
         end
         consume(0, stable, idle);
         checks++;
         if (o_crc_err !== 1'b0) begin
            failures++;
            $display("FAIL check_err_qualified exp=%b: got err=%b required 0", ex[n], o_crc_err);
         end
         $display("check_en exp=%b crc=%b", ex[n], got);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_chunk();
      test_chain_stalls();
      test_zero_len_backpressure();
      test_reset_mid_job();
      test_back_to_back();
      test_random();
`ifdef CRC_SEQ_CHECK_EN
      test_check_en();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/crc_seq_ctrl.md
Name:
crc_seq_ctrl

Overview:
- Sequential controller that drives the team's combinational CRC step (`crc3_eval`) across a multi-chunk message, one WCODE-bit chunk per cycle.
- Chains the running remainder from chunk to chunk.
- Accepts a job descriptor, then a data stream, both over valid/ready; returns the final CRC over a valid/ready result channel.
- Sits between the ALU command decoder and the CRC datapath.

Parameters:
- WCODE, 4, chunk (data word) width in bits.
- WPOLY, 3, polynomial width; remainder width is WPOLY-1.
- LENW, 8, width of the chunk-count field; maximum message length 2^LENW-1 chunks.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  job request; accepted only while o_busy=0.
- i_len  in  LENW  number of chunks in the job, sampled at start.
- i_poly  in  WPOLY  generator polynomial, sampled at start.
- i_init  in  WPOLY-1  initial remainder, sampled at start.
- i_data  in  WCODE  message chunk, MSB-first chunk order.
- i_data_valid  in  1  chunk present.
- o_data_ready  out  1  controller accepts a chunk this cycle.
- o_crc  out  WPOLY-1  final remainder.
- o_crc_valid  out  1  result present.
- i_crc_ready  in  1  consumer takes the result.
- o_busy  out  1  job in progress (BUSY or DONE state).

Behaviour:
- Step function F(d,p,c):
  - t={d,c}; q={p,(WCODE-1)'b0}.
  - For i=WCODE-1 down to 0: if d[i] then t^=q; then q>>=1.
  - Result is t[WPOLY-2:0].
  - Implemented by instantiating `crc3_eval` with matching parameters.
- Registers: state, cnt[LENW-1:0], poly_r, crc_r. The `crc3_eval` inputs are i_data, poly_r, crc_r.
- FSM states: IDLE, BUSY, DONE.
- IDLE, on i_start=1:
  - Latch poly_r=i_poly, crc_r=i_init, cnt=i_len.
  - If i_len==0, go to DONE (result = i_init); otherwise go to BUSY.
- BUSY:
  - o_data_ready=1.
  - On i_data_valid&&o_data_ready: crc_r<=F(i_data,poly_r,crc_r); cnt<=cnt-1.
  - If cnt==1 at the beat, go to DONE.
  - No beat means no change (stalls of any length allowed).
- DONE:
  - o_crc_valid=1; o_crc=crc_r, held stable until i_crc_ready=1.
  - Then return to IDLE.
- Latency: o_crc_valid rises the cycle after the last accepted beat. Max throughput is 1 chunk/cycle.
- o_data_ready=0 outside BUSY; i_data/i_data_valid are ignored there.
- i_start while o_busy=1 is ignored (no queueing, no latch change).
- i_start in the same cycle the FSM returns DONE->IDLE is not accepted; it is accepted the following cycle.
- Outputs are registered or decoded from state only; no combinational path from i_data_valid to o_data_ready.
- Reset (any time, including mid-job): state=IDLE, cnt=0, poly_r=0, crc_r=0, o_crc=0, o_crc_valid=0, o_data_ready=0, o_busy=0. A partial job is discarded.
- Width rules:
  - cnt decrements only in BUSY with cnt>=1, so it never wraps.
  - All CRC arithmetic is XOR within WPOLY-1 bits; no carries.

Optional Feature:
- Macro CRC_SEQ_CHECK_EN.
- Defined:
  - Adds i_exp_crc (in, WPOLY-1), sampled at start into exp_r (reset 0).
  - Adds o_crc_err (out, 1) = (crc_r!=exp_r), qualified by o_crc_valid; 0 whenever o_crc_valid=0.
- Undefined: neither port nor exp_r exists. Behaviour is otherwise identical.

Test Plan:
- Reset then idle: after i_rst_n 0->1, outputs all 0 and o_data_ready=0 for 10 cycles with i_data_valid=1.
- Single chunk: poly=3'b101, init=2'b00, len=1, data=4'b0001 -> o_crc=2'b01, o_crc_valid the cycle after the beat. Repeat with data=4'b1111 -> 2'b11.
- Chaining plus stalls: poly=101, init=00, len=2, data 0001,0001 with 3 idle cycles between beats -> o_crc=00; o_data_ready stays 1 through the stalls.
- Zero length and backpressure: len=0, init=2'b10 -> DONE next cycle, o_crc=10. Hold i_crc_ready=0 for 5 cycles: o_crc/o_crc_valid stable; a second i_start during this is ignored.
- Reset mid-job: len=4, assert i_rst_n=0 after 2 beats -> immediate IDLE. A new job (len=1, 0001, init 00) then yields 01.
- With CRC_SEQ_CHECK_EN:
  - Exp 2'b01 on the single-chunk 0001 job -> o_crc_err=0.
  - Exp 2'b10 on the same job -> o_crc_err=1, only while o_crc_valid=1.
